axil_reg_bridge: RTL

// AXI4-Lite slave that converts host register accesses into the single-request/ack reg bus
// (reg_req/reg_rd_wr_L/reg_addr/reg_wr_data -> reg_ack/reg_rd_data) driving the pipeline register files.

---
 rtl/axil_reg_bridge.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave to single-request/ack reg bus bridge.
// Define REG_BRIDGE_TIMEOUT_EN to answer SLVERR when reg_ack never arrives.
`timescale 1ns/1ps

module axil_reg_bridge #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 26,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   output logic                        reg_req,
   output logic                        reg_rd_wr_L,
   output logic [AXI_ADDR_WIDTH-1:0]   reg_addr,
   output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data,
   input  logic                        reg_ack,
   input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      RESP
   } state_t;

   localparam logic [1:0] OKAY = 2'b00;

`ifdef REG_BRIDGE_TIMEOUT_EN
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [AXI_DATA_WIDTH-1:0] TMO_DATA =
      AXI_DATA_WIDTH'(32'hDEAD_BEEF);
   logic [7:0] tmo_cnt;
`endif

   state_t state;
   logic   prio_rd;

   logic aw_held;
   logic w_held;
   logic ar_held;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [AXI_DATA_WIDTH-1:0] w_data;

   logic aw_fire;
   logic w_fire;
   logic ar_fire;
   logic b_fire;
   logic r_fire;
   logic aw_held_nxt;
   logic w_held_nxt;
   logic ar_held_nxt;
   logic wr_pend;
   logic grant_wr;

   // Byte strobes carry no meaning here: every write is a full word.
   logic unused;
   assign unused = ^{s_axi_wstrb, 8'(TIMEOUT_CYCLES)};

   // Handshakes, next holding-register occupancy and arbitration choice.
   always_comb begin
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      ar_fire = s_axi_arvalid && s_axi_arready;
      b_fire  = s_axi_bvalid && s_axi_bready;
      r_fire  = s_axi_rvalid && s_axi_rready;

      aw_held_nxt = aw_held;
      if (b_fire)
         aw_held_nxt = 1'b0;
      else if (aw_fire)
         aw_held_nxt = 1'b1;

      w_held_nxt = w_held;
      if (b_fire)
         w_held_nxt = 1'b0;
      else if (w_fire)
         w_held_nxt = 1'b1;

      ar_held_nxt = ar_held;
      if (r_fire)
         ar_held_nxt = 1'b0;
      else if (ar_fire)
         ar_held_nxt = 1'b1;

      wr_pend  = aw_held && w_held;
      grant_wr = wr_pend && (!ar_held || !prio_rd);
   end

   // Holding registers; each ready is high exactly while its slot is empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         ar_held       <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         ar_addr       <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_arready <= 1'b0;
      end else begin
         aw_held       <= aw_held_nxt;
         w_held        <= w_held_nxt;
         ar_held       <= ar_held_nxt;
         s_axi_awready <= !aw_held_nxt;
         s_axi_wready  <= !w_held_nxt;
         s_axi_arready <= !ar_held_nxt;
         if (aw_fire)
            aw_addr <= s_axi_awaddr;
         if (w_fire)
            w_data <= s_axi_wdata;
         if (ar_fire)
            ar_addr <= s_axi_araddr;
      end
   end

   // Access sequencer: grant, one-cycle request, wait for ack, respond.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         prio_rd      <= 1'b0;
         reg_req      <= 1'b0;
         reg_rd_wr_L  <= 1'b1;
         reg_addr     <= '0;
         reg_wr_data  <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= OKAY;
         s_axi_rdata  <= '0;
`ifdef REG_BRIDGE_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (wr_pend || ar_held) begin
                  if (grant_wr) begin
                     reg_rd_wr_L <= 1'b0;
                     reg_addr    <= aw_addr;
                     reg_wr_data <= w_data;
                  end else begin
                     reg_rd_wr_L <= 1'b1;
                     reg_addr    <= ar_addr;
                  end
                  prio_rd <= !prio_rd;
                  reg_req <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               reg_req <= 1'b0;
               state   <= WAIT_ACK;
`ifdef REG_BRIDGE_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_ACK: begin
               if (reg_ack) begin
                  if (reg_rd_wr_L) begin
                     s_axi_rdata  <= reg_rd_data;
                     s_axi_rresp  <= OKAY;
                     s_axi_rvalid <= 1'b1;
                  end else begin
                     s_axi_bresp  <= OKAY;
                     s_axi_bvalid <= 1'b1;
                  end
                  state <= RESP;
               end
`ifdef REG_BRIDGE_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  if (reg_rd_wr_L) begin
                     s_axi_rdata  <= TMO_DATA;
                     s_axi_rresp  <= SLVERR;
                     s_axi_rvalid <= 1'b1;
                  end else begin
                     s_axi_bresp  <= SLVERR;
                     s_axi_bvalid <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            RESP: begin
               if (b_fire || r_fire) begin
                  s_axi_bvalid <= 1'b0;
                  s_axi_rvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
